mcpu_ctrl: RTL and testbench

Multi-cycle MIPS-subset control unit for the MCPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. Each cycle it drives the datapath enables, the mux selects and the 3-bit ALU_operation code consumed by the ALU. It sits directly upstream of the ALU and stalls on memory through a ready handshake.

---
 rtl/mcpu_pkg.sv | 54 +++++
 rtl/alu_op_decode.sv | 25 ++
 rtl/mcpu_ctrl.sv | 146 ++++++++++++++
 tb/tb_mcpu_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared encodings for the MCPU multi-cycle control unit
package mcpu_pkg;

   typedef enum logic [3:0] {
      S_IF       = 4'd0,
      S_ID       = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_WB_LW    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EX_R     = 4'd6,
      S_WB_R     = 4'd7,
      S_EX_BEQ   = 4'd8,
      S_EX_J     = 4'd9,
      S_EX_I     = 4'd10,
      S_WB_I     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Ordering matches the ALU result mux inputs
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - R-type funct field to ALU_operation decode
module alu_op_decode
   import mcpu_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op
);

   // Unlisted functs fall back to ADD so the write-back stays harmless
   always_comb begin
      alu_op = ALU_ADD;
      case (funct)
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_ADD:  alu_op = ALU_ADD;
         FN_XOR:  alu_op = ALU_XOR;
         FN_NOR:  alu_op = ALU_NOR;
         FN_SRL:  alu_op = ALU_SRL;
         FN_SUB:  alu_op = ALU_SUB;
         FN_SLT:  alu_op = ALU_SLT;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multi-cycle MIPS-subset control FSM for the MCPU datapath
module mcpu_ctrl
   import mcpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Inst_in,
   input  logic        zero,
   input  logic        MIO_ready,
   output logic        CPU_MIO,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IorD,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        Branch,
   output logic [2:0]  ALU_operation,
   output logic [3:0]  state_out
);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] opcode;
   logic [2:0] funct_op;

   assign opcode    = Inst_in[31:26];
   assign state_out = state;

   // zero is consumed by the datapath's PCWriteCond gate, not by the FSM
   logic unused_inputs;
   assign unused_inputs = &{1'b0, Inst_in[25:6], zero};

   alu_op_decode u_alu_op_decode (
      .funct  (Inst_in[5:0]),
      .alu_op (funct_op)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IF;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = S_IF;
      CPU_MIO       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      MemtoReg      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_B;
      PCSource      = PCS_ALU;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      Branch        = 1'b0;
      ALU_operation = ALU_ADD;

      // Reset masks every strobe so a half-finished instruction cannot write
      if (!rst) begin
         case (state)
            S_IF: begin
               CPU_MIO   = 1'b1;
               MemRead   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               IRWrite   = MIO_ready;
               PCWrite   = MIO_ready;
               state_nxt = MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
               ALUSrcB = SRCB_IMM_SH2;
               case (opcode)
                  OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                  OP_RTYPE:     state_nxt = S_EX_R;
                  OP_BEQ:       state_nxt = S_EX_BEQ;
                  OP_J:         state_nxt = S_EX_J;
                  OP_ADDI:      state_nxt = S_EX_I;
                  default:      state_nxt = S_IF;
               endcase
            end
            S_MEM_ADDR: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_IMM;
               state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               CPU_MIO   = 1'b1;
               MemRead   = 1'b1;
               IorD      = 1'b1;
               state_nxt = MIO_ready ? S_WB_LW : S_MEM_RD;
            end
            S_WB_LW: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
               CPU_MIO   = 1'b1;
               MemWrite  = 1'b1;
               IorD      = 1'b1;
               state_nxt = MIO_ready ? S_IF : S_MEM_WR;
            end
            S_EX_R: begin
               ALUSrcA       = 1'b1;
               ALU_operation = funct_op;
               state_nxt     = S_WB_R;
            end
            S_WB_R: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_EX_BEQ: begin
               ALUSrcA       = 1'b1;
               ALU_operation = ALU_SUB;
               PCWriteCond   = 1'b1;
               PCSource      = PCS_ALUOUT;
               Branch        = 1'b1;
            end
            S_EX_J: begin
               PCWrite  = 1'b1;
               PCSource = PCS_JUMP;
            end
            S_EX_I: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_IMM;
               state_nxt = S_WB_I;
            end
            S_WB_I: begin
               RegWrite = 1'b1;
            end
            default: state_nxt = S_IF;
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - directed scoreboard bench for mcpu_ctrl
module tb_mcpu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Inst_in;
   logic        zero;
   logic        MIO_ready;
   logic        CPU_MIO, MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA;
   logic [1:0]  ALUSrcB, PCSource;
   logic        PCWrite, PCWriteCond, Branch;
   logic [2:0]  ALU_operation;
   logic [3:0]  state_out;

   always #5 clk = ~clk;

   mcpu_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .Inst_in       (Inst_in),
      .zero          (zero),
      .MIO_ready     (MIO_ready),
      .CPU_MIO       (CPU_MIO),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .IorD          (IorD),
      .IRWrite       (IRWrite),
      .RegDst        (RegDst),
      .RegWrite      (RegWrite),
      .MemtoReg      (MemtoReg),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .PCSource      (PCSource),
      .PCWrite       (PCWrite),
      .PCWriteCond   (PCWriteCond),
      .Branch        (Branch),
      .ALU_operation (ALU_operation),
      .state_out     (state_out)
   );

   typedef struct packed {
      logic       cpu, mr, mw, iord, irw, regdst, regw, m2r, srca;
      logic [1:0] srcb, pcs;
      logic       pcw, pcwc, br;
      logic [2:0] alu;
      logic [3:0] st;
   } out_t;

   out_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [5:0] fn_tab [9] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h02, 6'h22, 6'h2A, 6'h00};
   logic [2:0] op_tab [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};

   function automatic out_t dflt(input logic [3:0] st);
      out_t o;
      o     = '0;
      o.alu = 3'b010;
      o.st  = st;
      return o;
   endfunction

   function automatic out_t x_if(input logic r);
      out_t o = dflt(4'd0);
      o.cpu = 1'b1; o.mr = 1'b1; o.srcb = 2'b01; o.irw = r; o.pcw = r;
      return o;
   endfunction
   function automatic out_t x_id();
      out_t o = dflt(4'd1);
      o.srcb = 2'b11;
      return o;
   endfunction
   function automatic out_t x_ma();
      out_t o = dflt(4'd2);
      o.srca = 1'b1; o.srcb = 2'b10;
      return o;
   endfunction
   function automatic out_t x_mr();
      out_t o = dflt(4'd3);
      o.cpu = 1'b1; o.mr = 1'b1; o.iord = 1'b1;
      return o;
   endfunction
   function automatic out_t x_wl();
      out_t o = dflt(4'd4);
      o.regw = 1'b1; o.m2r = 1'b1;
      return o;
   endfunction
   function automatic out_t x_mw();
      out_t o = dflt(4'd5);
      o.cpu = 1'b1; o.mw = 1'b1; o.iord = 1'b1;
      return o;
   endfunction
   function automatic out_t x_er(input logic [2:0] alu);
      out_t o = dflt(4'd6);
      o.srca = 1'b1; o.alu = alu;
      return o;
   endfunction
   function automatic out_t x_wr();
      out_t o = dflt(4'd7);
      o.regdst = 1'b1; o.regw = 1'b1;
      return o;
   endfunction
   function automatic out_t x_eb();
      out_t o = dflt(4'd8);
      o.srca = 1'b1; o.alu = 3'b110; o.pcwc = 1'b1; o.pcs = 2'b01; o.br = 1'b1;
      return o;
   endfunction
   function automatic out_t x_ej();
      out_t o = dflt(4'd9);
      o.pcw = 1'b1; o.pcs = 2'b10;
      return o;
   endfunction
   function automatic out_t x_ei();
      out_t o = dflt(4'd10);
      o.srca = 1'b1; o.srcb = 2'b10;
      return o;
   endfunction
   function automatic out_t x_wi();
      out_t o = dflt(4'd11);
      o.regw = 1'b1;
      return o;
   endfunction

   // Called at a falling edge with inputs already driven; consumes one clock
   task automatic cyc(input out_t e, input string tag);
      out_t got;
      out_t exp;
      q.push_back(e);
      #2;
      got = {CPU_MIO, MemRead, MemWrite, IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA,
             ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch, ALU_operation, state_out};
      exp = q.pop_front();
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      zero      = 1'b0;
      MIO_ready = 1'b1;
      Inst_in   = 32'h0;
      @(negedge clk);
      cyc(dflt(4'd0), "reset_hold");
      rst = 1'b0;

      Inst_in = 32'h8C220004;
      cyc(x_if(1'b1), "lw_if");
      cyc(x_id(),     "lw_id");
      cyc(x_ma(),     "lw_ma");
      cyc(x_mr(),     "lw_mr");
      cyc(x_wl(),     "lw_wb");

      cyc(x_if(1'b1), "lwst_if");
      cyc(x_id(),     "lwst_id");
      cyc(x_ma(),     "lwst_ma");
      MIO_ready = 1'b0;
      cyc(x_mr(),     "lwst_mr_wait0");
      cyc(x_mr(),     "lwst_mr_wait1");
      MIO_ready = 1'b1;
      cyc(x_mr(),     "lwst_mr_done");
      cyc(x_wl(),     "lwst_wb");

      for (int i = 0; i < 9; i++) begin
         Inst_in = 32'h00221800 | {26'd0, fn_tab[i]};
         cyc(x_if(1'b1),    "r_if");
         cyc(x_id(),        "r_id");
         cyc(x_er(op_tab[i]), "r_ex_funct");
         cyc(x_wr(),        "r_wb");
      end

      Inst_in = 32'h10220003;
      for (int z = 1; z >= 0; z--) begin
         zero = z[0];
         cyc(x_if(1'b1), "beq_if");
         cyc(x_id(),     "beq_id");
         cyc(x_eb(),     "beq_ex");
      end
      zero = 1'b0;

      Inst_in = 32'hAC220004;
      cyc(x_if(1'b1), "sw_if");
      cyc(x_id(),     "sw_id");
      cyc(x_ma(),     "sw_ma");
      MIO_ready = 1'b0;
      for (int k = 0; k < 3; k++) cyc(x_mw(), "sw_mw_stall");
      MIO_ready = 1'b1;
      cyc(x_mw(),     "sw_mw_done");

      MIO_ready = 1'b0;
      Inst_in   = 32'h20220005;
      cyc(x_if(1'b0), "if_stall0");
      cyc(x_if(1'b0), "if_stall1");
      MIO_ready = 1'b1;
      cyc(x_if(1'b1), "if_stall_done");
      cyc(x_id(),     "addi_id");
      cyc(x_ei(),     "addi_ex");
      cyc(x_wi(),     "addi_wb");

      Inst_in = 32'hAC220004;
      cyc(x_if(1'b1), "swrst_if");
      cyc(x_id(),     "swrst_id");
      cyc(x_ma(),     "swrst_ma");
      MIO_ready = 1'b0;
      cyc(x_mw(),     "swrst_mw");
      rst = 1'b1;
      cyc(dflt(4'd5), "swrst_rst_forced");
      rst = 1'b0;
      cyc(x_if(1'b0), "swrst_after");
      MIO_ready = 1'b1;

      Inst_in = 32'hFC000000;
      cyc(x_if(1'b1), "ill_if");
      cyc(x_id(),     "ill_id");
      Inst_in = 32'h08000010;
      cyc(x_if(1'b1), "ill_back_to_if");
      cyc(x_id(),     "j_id");
      cyc(x_ej(),     "j_ex");
      cyc(x_if(1'b1), "j_done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
